step_controller: RTL and testbench

STEP_CONTROLLER -- requirements
Module: step_controller

---
 rtl/step_ctrl_pkg.sv | 22 ++
 rtl/btn_debouncer.sv | 60 ++++++
 rtl/step_controller.sv | 147 ++++++++++++++
 tb/tb_step_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// step_ctrl_pkg : mode encodings and FSM state type for step_controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package step_ctrl_pkg;

  localparam logic [1:0] MODE_HALT   = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;
  localparam logic [1:0] MODE_BURST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ARMED = 2'd2,
    ST_BURST = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer : 2-flop synchronizer plus stable-count debouncer, press pulse. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // Any cycle where the synced level agrees with the accepted level restarts the count.
  always_comb begin
    sync_d   = {sync_q[0], raw_i};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
      press_d  = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

`default_nettype wire

// File: rtl/step_controller.sv
// ---------------------------------------------------------------------------
// step_controller : CPU single-step / run / burst enable generator. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  input  logic [7:0]  burst_len,
  input  logic        cnt_clr,
  output logic        cpu_step,
  output logic        busy,
  output logic [15:0] step_count
);

  logic [1:0]  tick_sync_q;
  logic        tick_prev_q;
  logic [1:0]  tick_vld_q;
  logic        tick_low_seen_q;
  logic        tick_edge;

  state_e      state_q, state_d;
  logic [7:0]  remaining_q, remaining_d;
  logic        cpu_step_q, cpu_step_d;
  logic [15:0] step_count_q, step_count_d;

  logic        btn_stable;
  logic        press;

  btn_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debouncer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .raw_i    (step_btn),
    .stable_o (btn_stable),
    .press_o  (press)
  );

  // tick_vld_q marks when the synchronizer output reflects the real input, so a
  // tick already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync_q     <= 2'b00;
      tick_prev_q     <= 1'b0;
      tick_vld_q      <= 2'b00;
      tick_low_seen_q <= 1'b0;
    end else begin
      tick_sync_q <= {tick_sync_q[0], tick_in};
      tick_prev_q <= tick_sync_q[1];
      tick_vld_q  <= {tick_vld_q[0], 1'b1};
      if (tick_vld_q[1] && !tick_sync_q[1]) begin
        tick_low_seen_q <= 1'b1;
      end
    end
  end

  assign tick_edge = tick_sync_q[1] & ~tick_prev_q & tick_low_seen_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= 8'd0;
      cpu_step_q   <= 1'b0;
      step_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      cpu_step_q   <= cpu_step_d;
      step_count_q <= step_count_d;
    end
  end

  // Mode checks come before tick_edge so a cancelling mode change always wins.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cpu_step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
        end else if (mode == MODE_SINGLE && press) begin
          state_d = ST_ARMED;
        end else if (mode == MODE_BURST && press && burst_len != 8'd0) begin
          state_d     = ST_BURST;
          remaining_d = burst_len;
        end
      end
      ST_RUN: begin
        if (mode != MODE_RUN) begin
          state_d = ST_IDLE;
        end else if (tick_edge) begin
          cpu_step_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (mode != MODE_SINGLE) begin
          state_d     = ST_IDLE;
          remaining_d = 8'd0;
        end else if (tick_edge) begin
          cpu_step_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (mode != MODE_BURST) begin
          state_d     = ST_IDLE;
          remaining_d = 8'd0;
        end else if (tick_edge) begin
          cpu_step_d  = 1'b1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    step_count_d = step_count_q;
    if (cnt_clr) begin
      step_count_d = 16'd0;
    end else if (cpu_step_q) begin
      step_count_d = step_count_q + 16'd1;
    end
  end

  assign cpu_step   = cpu_step_q;
  assign busy       = (state_q == ST_ARMED) || (state_q == ST_BURST);
  assign step_count = step_count_q;

endmodule

`default_nettype wire

// File: tb/tb_step_controller.sv
// ---------------------------------------------------------------------------
// tb_step_controller : directed scoreboard bench for step_controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_step_controller;

  logic        clk_in;
  logic        rst_n;
  logic        tick_in;
  logic [1:0]  mode;
  logic        step_btn;
  logic [7:0]  burst_len;
  logic        cnt_clr;
  logic        cpu_step;
  logic        busy;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int mon_exp;

  step_controller #(
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .mode       (mode),
    .step_btn   (step_btn),
    .burst_len  (burst_len),
    .cnt_clr    (cnt_clr),
    .cpu_step   (cpu_step),
    .busy       (busy),
    .step_count (step_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Each step pushed by the stimulus carries the negedge cycle at which it must be seen.
  initial begin
    forever begin
      @(negedge clk_in);
      if (cpu_step === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_step: cpu_step=1 at cycle %0d, expected no step", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (cyc != mon_exp) begin
            errors++;
            $display("FAIL step_timing: step at cycle %0d, expected cycle %0d", cyc, mon_exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input bit expect_step);
    @(negedge clk_in);
    tick_in = 1'b1;
    if (expect_step) exp_q.push_back(cyc + 3);
    repeat (4) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic press_btn();
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1;
      repeat (3) @(negedge clk_in);
      step_btn = 1'b0;
      repeat (3) @(negedge clk_in);
    end
    step_btn = 1'b1;
    repeat (20) @(negedge clk_in);
    step_btn = 1'b0;
    repeat (20) @(negedge clk_in);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    tick_in   = 1'b0;
    mode      = 2'b00;
    step_btn  = 1'b0;
    burst_len = 8'd0;
    cnt_clr   = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_cpu_step", cpu_step, 0);
    check("reset_busy", busy, 0);
    check("reset_count", step_count, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);

    // RUN: five ticks, five steps
    mode = 2'b01;
    repeat (2) @(negedge clk_in);
    repeat (5) tick(1'b1);
    check("run_count", step_count, 5);

    // SINGLE with bouncing button
    mode = 2'b10;
    repeat (2) @(negedge clk_in);
    press_btn();
    check("single_busy_armed", busy, 1);
    tick(1'b1);
    check("single_busy_done", busy, 0);
    tick(1'b0);
    check("single_count", step_count, 6);

    // BURST of 3 with an ignored press mid-burst
    mode = 2'b11;
    burst_len = 8'd3;
    repeat (2) @(negedge clk_in);
    press_btn();
    check("burst3_busy", busy, 1);
    tick(1'b1);
    press_btn();
    tick(1'b1);
    check("burst3_busy_mid", busy, 1);
    tick(1'b1);
    check("burst3_busy_done", busy, 0);
    tick(1'b0);
    check("burst3_count", step_count, 9);

    // BURST with length 0 does nothing
    burst_len = 8'd0;
    press_btn();
    check("burst0_busy", busy, 0);
    tick(1'b0);
    check("burst0_count", step_count, 9);

    // BURST of 4 cancelled by HALT after 2 steps
    burst_len = 8'd4;
    press_btn();
    tick(1'b1);
    tick(1'b1);
    mode = 2'b00;
    @(negedge clk_in);
    check("cancel_busy", busy, 0);
    tick(1'b0);
    tick(1'b0);
    check("cancel_count", step_count, 11);

    // Cancel in the same cycle as tick_edge: no step
    mode = 2'b11;
    burst_len = 8'd2;
    repeat (2) @(negedge clk_in);
    press_btn();
    check("coincide_busy_before", busy, 1);
    @(negedge clk_in);
    tick_in = 1'b1;
    repeat (2) @(negedge clk_in);
    mode = 2'b00;
    @(negedge clk_in);
    check("coincide_busy_after", busy, 0);
    repeat (2) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (8) @(negedge clk_in);
    check("coincide_count", step_count, 11);

    // Wrap at 16'hFFFF and clear-wins
    force dut.step_count_q = 16'hFFFE;
    repeat (2) @(negedge clk_in);
    release dut.step_count_q;
    @(negedge clk_in);
    check("preload_count", step_count, 16'hFFFE);
    mode = 2'b01;
    repeat (2) @(negedge clk_in);
    tick(1'b1);
    check("wrap_ffff", step_count, 16'hFFFF);
    tick(1'b1);
    check("wrap_zero", step_count, 16'h0000);
    tick(1'b1);
    check("post_wrap_one", step_count, 16'h0001);
    @(negedge clk_in);
    tick_in = 1'b1;
    exp_q.push_back(cyc + 3);
    repeat (3) @(negedge clk_in);
    cnt_clr = 1'b1;
    @(negedge clk_in);
    cnt_clr = 1'b0;
    check("clear_wins", step_count, 0);
    tick_in = 1'b0;
    repeat (4) @(negedge clk_in);

    // Reset mid-BURST with tick high, released with tick still high
    mode = 2'b11;
    burst_len = 8'd4;
    repeat (2) @(negedge clk_in);
    press_btn();
    tick(1'b1);
    check("pre_reset_count", step_count, 1);
    @(negedge clk_in);
    tick_in = 1'b1;
    @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    check("midreset_cpu_step", cpu_step, 0);
    check("midreset_busy", busy, 0);
    check("midreset_count", step_count, 0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (12) @(negedge clk_in);
    check("post_reset_busy", busy, 0);
    check("post_reset_count", step_count, 0);
    tick_in = 1'b0;
    repeat (6) @(negedge clk_in);
    mode = 2'b01;
    repeat (2) @(negedge clk_in);
    tick(1'b1);
    check("post_reset_run_count", step_count, 1);

    repeat (10) @(negedge clk_in);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
